// File: rtl/gpu_pkg.sv
// Shared constants, state encoding and record layout for the triangle setup stage.
package gpu_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 400;
  localparam int COORD_W = 10;
  localparam int COEF_W  = COORD_W + 1;
  localparam int EDGE_W  = 24;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    BBOX   = 4'd1,
    COEF   = 4'd2,
    EVAL0  = 4'd3,
    EVAL1  = 4'd4,
    EVAL2  = 4'd5,
    AREA   = 4'd6,
    ORIENT = 4'd7,
    OUT    = 4'd8
  } setup_state_t;

  typedef struct packed {
    logic        [COORD_W-1:0] x_min;
    logic        [COORD_W-1:0] x_max;
    logic        [COORD_W-1:0] y_min;
    logic        [COORD_W-1:0] y_max;
    logic signed [COEF_W-1:0]  a0;
    logic signed [COEF_W-1:0]  b0;
    logic signed [COEF_W-1:0]  a1;
    logic signed [COEF_W-1:0]  b1;
    logic signed [COEF_W-1:0]  a2;
    logic signed [COEF_W-1:0]  b2;
    logic signed [EDGE_W-1:0]  e0;
    logic signed [EDGE_W-1:0]  e1;
    logic signed [EDGE_W-1:0]  e2;
    logic        [15:0]        color;
  } setup_rec_t;

  // Ties resolve to the lower-index vertex; the value is identical either way.
  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] v0,
                                              input logic [COORD_W-1:0] v1,
                                              input logic [COORD_W-1:0] v2);
    logic [COORD_W-1:0] m;
    m = (v0 <= v1) ? v0 : v1;
    return (m <= v2) ? m : v2;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] v0,
                                              input logic [COORD_W-1:0] v1,
                                              input logic [COORD_W-1:0] v2);
    logic [COORD_W-1:0] m;
    m = (v0 >= v1) ? v0 : v1;
    return (m >= v2) ? m : v2;
  endfunction

  function automatic logic signed [COEF_W-1:0] sdiff(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

endpackage

// File: rtl/edge_mac.sv
// Combinational signed a*dx + b*dy, shared by the edge and area evaluations.
module edge_mac
  import gpu_pkg::*;
(
  input  logic signed [COEF_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  input  logic signed [COEF_W-1:0] dx,
  input  logic signed [COEF_W-1:0] dy,
  output logic signed [EDGE_W-1:0] sum
);

  logic signed [EDGE_W-1:0] a_w;
  logic signed [EDGE_W-1:0] b_w;
  logic signed [EDGE_W-1:0] dx_w;
  logic signed [EDGE_W-1:0] dy_w;

  // 11x11 products plus their sum stay well inside EDGE_W, so truncation is exact.
  assign a_w  = EDGE_W'(a);
  assign b_w  = EDGE_W'(b);
  assign dx_w = EDGE_W'(dx);
  assign dy_w = EDGE_W'(dy);
  assign sum  = (a_w * dx_w) + (b_w * dy_w);

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: bounding box, edge coefficients, origin edge values, winding and cull.
//
// state  | meaning
// IDLE   | ready for a triangle, vertices captured on accept
// BBOX   | bounding box from the captured vertices
// COEF   | edge coefficients A/B
// EVAL0  | E0 through the shared MAC
// EVAL1  | E1
// EVAL2  | E2
// AREA   | signed doubled area
// ORIENT | cull check, winding normalisation, clamp
// OUT    | record held until the rasterizer takes it
module tri_setup
  import gpu_pkg::*;
(
  input  logic                      I_CLK,
  input  logic                      I_RST_N,
  input  logic                      I_TRI_VALID,
  output logic                      O_TRI_READY,
  input  logic        [COORD_W-1:0] I_P0X,
  input  logic        [COORD_W-1:0] I_P0Y,
  input  logic        [COORD_W-1:0] I_P1X,
  input  logic        [COORD_W-1:0] I_P1Y,
  input  logic        [COORD_W-1:0] I_P2X,
  input  logic        [COORD_W-1:0] I_P2Y,
  input  logic        [15:0]        I_COLOR,
  output logic                      O_SETUP_VALID,
  input  logic                      I_SETUP_READY,
  output logic        [COORD_W-1:0] O_X_MIN,
  output logic        [COORD_W-1:0] O_X_MAX,
  output logic        [COORD_W-1:0] O_Y_MIN,
  output logic        [COORD_W-1:0] O_Y_MAX,
  output logic signed [COEF_W-1:0]  O_A0,
  output logic signed [COEF_W-1:0]  O_B0,
  output logic signed [COEF_W-1:0]  O_A1,
  output logic signed [COEF_W-1:0]  O_B1,
  output logic signed [COEF_W-1:0]  O_A2,
  output logic signed [COEF_W-1:0]  O_B2,
  output logic signed [EDGE_W-1:0]  O_E0,
  output logic signed [EDGE_W-1:0]  O_E1,
  output logic signed [EDGE_W-1:0]  O_E2,
  output logic        [15:0]        O_COLOR,
  output logic                      O_CULL
);

  setup_state_t             state;
  setup_rec_t               rec;
  logic [COORD_W-1:0]       p0x, p0y, p1x, p1y, p2x, p2y;
  logic signed [EDGE_W-1:0] area;
  logic                     setup_valid;
  logic                     cull;
  logic                     drop;

  logic signed [COEF_W-1:0] mac_a, mac_b, mac_dx, mac_dy;
  logic signed [EDGE_W-1:0] mac_sum;

  // Each EVAL/AREA state feeds its own edge and reference vertex to the single MAC.
  always_comb begin
    mac_a  = rec.a0;
    mac_b  = rec.b0;
    mac_dx = sdiff(rec.x_min, p1x);
    mac_dy = sdiff(rec.y_min, p1y);
    case (state)
      EVAL1: begin
        mac_a  = rec.a1;
        mac_b  = rec.b1;
        mac_dx = sdiff(rec.x_min, p2x);
        mac_dy = sdiff(rec.y_min, p2y);
      end
      EVAL2: begin
        mac_a  = rec.a2;
        mac_b  = rec.b2;
        mac_dx = sdiff(rec.x_min, p0x);
        mac_dy = sdiff(rec.y_min, p0y);
      end
      AREA: begin
        mac_a  = rec.a0;
        mac_b  = rec.b0;
        mac_dx = sdiff(p0x, p1x);
        mac_dy = sdiff(p0y, p1y);
      end
      default: ;
    endcase
  end

  edge_mac u_edge_mac (
    .a   (mac_a),
    .b   (mac_b),
    .dx  (mac_dx),
    .dy  (mac_dy),
    .sum (mac_sum)
  );

  assign drop = (area == '0) || (rec.x_min > X_LAST) || (rec.y_min > Y_LAST);

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      state       <= IDLE;
      rec         <= '0;
      p0x         <= '0;
      p0y         <= '0;
      p1x         <= '0;
      p1y         <= '0;
      p2x         <= '0;
      p2y         <= '0;
      area        <= '0;
      setup_valid <= 1'b0;
      cull        <= 1'b0;
    end else begin
      cull <= 1'b0;
      case (state)
        IDLE: begin
          if (I_TRI_VALID) begin
            p0x       <= I_P0X;
            p0y       <= I_P0Y;
            p1x       <= I_P1X;
            p1y       <= I_P1Y;
            p2x       <= I_P2X;
            p2y       <= I_P2Y;
            rec.color <= I_COLOR;
            state     <= BBOX;
          end
        end
        BBOX: begin
          rec.x_min <= min3(p0x, p1x, p2x);
          rec.x_max <= max3(p0x, p1x, p2x);
          rec.y_min <= min3(p0y, p1y, p2y);
          rec.y_max <= max3(p0y, p1y, p2y);
          state     <= COEF;
        end
        COEF: begin
          rec.a0 <= -sdiff(p2y, p1y);
          rec.b0 <=  sdiff(p2x, p1x);
          rec.a1 <= -sdiff(p0y, p2y);
          rec.b1 <=  sdiff(p0x, p2x);
          rec.a2 <= -sdiff(p1y, p0y);
          rec.b2 <=  sdiff(p1x, p0x);
          state  <= EVAL0;
        end
        EVAL0: begin
          rec.e0 <= mac_sum;
          state  <= EVAL1;
        end
        EVAL1: begin
          rec.e1 <= mac_sum;
          state  <= EVAL2;
        end
        EVAL2: begin
          rec.e2 <= mac_sum;
          state  <= AREA;
        end
        AREA: begin
          area  <= mac_sum;
          state <= ORIENT;
        end
        ORIENT: begin
          if (drop) begin
            cull  <= 1'b1;
            state <= IDLE;
          end else begin
            // Clockwise input: flip every edge so inside is always E >= 0.
            if (area < 0) begin
              rec.a0 <= -rec.a0;
              rec.b0 <= -rec.b0;
              rec.a1 <= -rec.a1;
              rec.b1 <= -rec.b1;
              rec.a2 <= -rec.a2;
              rec.b2 <= -rec.b2;
              rec.e0 <= -rec.e0;
              rec.e1 <= -rec.e1;
              rec.e2 <= -rec.e2;
            end
            if (rec.x_max > X_LAST) rec.x_max <= X_LAST;
            if (rec.y_max > Y_LAST) rec.y_max <= Y_LAST;
            setup_valid <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (I_SETUP_READY) begin
            setup_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign O_TRI_READY   = (state == IDLE);
  assign O_SETUP_VALID = setup_valid;
  assign O_CULL        = cull;
  assign O_X_MIN       = rec.x_min;
  assign O_X_MAX       = rec.x_max;
  assign O_Y_MIN       = rec.y_min;
  assign O_Y_MAX       = rec.y_max;
  assign O_A0          = rec.a0;
  assign O_B0          = rec.b0;
  assign O_A1          = rec.a1;
  assign O_B1          = rec.b1;
  assign O_A2          = rec.a2;
  assign O_B2          = rec.b2;
  assign O_E0          = rec.e0;
  assign O_E1          = rec.e1;
  assign O_E2          = rec.e2;
  assign O_COLOR       = rec.color;

endmodule

// File: tb/tb_tri_setup.sv
// Self-checking bench for tri_setup: arithmetic model, per-cycle compare, directed triangles.
module tb_tri_setup;

  logic                I_CLK = 1'b0;
  logic                I_RST_N = 1'b0;
  logic                I_TRI_VALID = 1'b0;
  logic                I_SETUP_READY = 1'b0;
  logic [9:0]          I_P0X = '0, I_P0Y = '0, I_P1X = '0, I_P1Y = '0, I_P2X = '0, I_P2Y = '0;
  logic [15:0]         I_COLOR = '0;
  logic                O_TRI_READY, O_SETUP_VALID, O_CULL;
  logic [9:0]          O_X_MIN, O_X_MAX, O_Y_MIN, O_Y_MAX;
  logic signed [10:0]  O_A0, O_B0, O_A1, O_B1, O_A2, O_B2;
  logic signed [23:0]  O_E0, O_E1, O_E2;
  logic [15:0]         O_COLOR;

  tri_setup dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N),
    .I_TRI_VALID(I_TRI_VALID), .O_TRI_READY(O_TRI_READY),
    .I_P0X(I_P0X), .I_P0Y(I_P0Y), .I_P1X(I_P1X), .I_P1Y(I_P1Y),
    .I_P2X(I_P2X), .I_P2Y(I_P2Y), .I_COLOR(I_COLOR),
    .O_SETUP_VALID(O_SETUP_VALID), .I_SETUP_READY(I_SETUP_READY),
    .O_X_MIN(O_X_MIN), .O_X_MAX(O_X_MAX), .O_Y_MIN(O_Y_MIN), .O_Y_MAX(O_Y_MAX),
    .O_A0(O_A0), .O_B0(O_B0), .O_A1(O_A1), .O_B1(O_B1), .O_A2(O_A2), .O_B2(O_B2),
    .O_E0(O_E0), .O_E1(O_E1), .O_E2(O_E2),
    .O_COLOR(O_COLOR), .O_CULL(O_CULL)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    int xmin, xmax, ymin, ymax;
    int a[3];
    int b[3];
    int e[3];
    int area;
    bit cull;
    int color;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_cur;
  bit   exp_live = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Edge i runs from vertex (i+1)%3 to (i+2)%3 and is evaluated relative to its start vertex.
  function automatic exp_t model(input int x0, input int y0, input int x1, input int y1,
                                 input int x2, input int y2, input int col);
    exp_t m;
    int xs[3];
    int ys[3];
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    ys[0] = y0; ys[1] = y1; ys[2] = y2;
    m.xmin = x0; m.xmax = x0; m.ymin = y0; m.ymax = y0;
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < m.xmin) m.xmin = xs[i];
      if (xs[i] > m.xmax) m.xmax = xs[i];
      if (ys[i] < m.ymin) m.ymin = ys[i];
      if (ys[i] > m.ymax) m.ymax = ys[i];
    end
    for (int i = 0; i < 3; i++) begin
      int j, k;
      j = (i + 1) % 3;
      k = (i + 2) % 3;
      m.a[i] = -(ys[k] - ys[j]);
      m.b[i] = xs[k] - xs[j];
      m.e[i] = m.a[i] * (m.xmin - xs[j]) + m.b[i] * (m.ymin - ys[j]);
    end
    m.area = m.a[0] * (x0 - x1) + m.b[0] * (y0 - y1);
    m.cull = (m.area == 0) || (m.xmin >= 640) || (m.ymin >= 400);
    if (m.area < 0) begin
      for (int i = 0; i < 3; i++) begin
        m.a[i] = -m.a[i];
        m.b[i] = -m.b[i];
        m.e[i] = -m.e[i];
      end
    end
    if (m.xmax > 639) m.xmax = 639;
    if (m.ymax > 399) m.ymax = 399;
    m.color = col;
    return m;
  endfunction

  logic [193:0] snap, cur_snap;
  bit           prev_hold = 0;
  assign cur_snap = {O_X_MIN, O_X_MAX, O_Y_MIN, O_Y_MAX, O_A0, O_B0, O_A1, O_B1,
                     O_A2, O_B2, O_E0, O_E1, O_E2, O_COLOR};

  // Compare process: every cycle a record or cull is visible, it must match the pending triangle.
  always @(negedge I_CLK) begin
    if (I_RST_N) begin
      if (O_SETUP_VALID) begin
        check("record_expected", int'(exp_live && !exp_cur.cull), 1);
        if (exp_live && !exp_cur.cull) begin
          check("x_min", O_X_MIN, exp_cur.xmin);
          check("x_max", O_X_MAX, exp_cur.xmax);
          check("y_min", O_Y_MIN, exp_cur.ymin);
          check("y_max", O_Y_MAX, exp_cur.ymax);
          check("a0", int'(O_A0), exp_cur.a[0]);
          check("b0", int'(O_B0), exp_cur.b[0]);
          check("a1", int'(O_A1), exp_cur.a[1]);
          check("b1", int'(O_B1), exp_cur.b[1]);
          check("a2", int'(O_A2), exp_cur.a[2]);
          check("b2", int'(O_B2), exp_cur.b[2]);
          check("e0", int'(O_E0), exp_cur.e[0]);
          check("e1", int'(O_E1), exp_cur.e[1]);
          check("e2", int'(O_E2), exp_cur.e[2]);
          check("color", O_COLOR, exp_cur.color);
        end
        check("tri_ready_while_valid", O_TRI_READY, 0);
        if (prev_hold) begin
          n_checks++;
          if (cur_snap !== snap) begin
            n_fail++;
            $display("FAIL hold_stable: got %h, expected %h", cur_snap, snap);
          end
        end
      end
      if (O_CULL) check("cull_expected", int'(exp_live && exp_cur.cull), 1);
      prev_hold = O_SETUP_VALID && !I_SETUP_READY;
      snap      = cur_snap;
    end else begin
      prev_hold = 0;
    end
  end

  task automatic wait_ready();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (O_TRI_READY) begin
        seen = 1;
        break;
      end
      @(posedge I_CLK); #1;
    end
    check("tri_ready_wait", int'(seen), 1);
  endtask

  task automatic send(input int x0, input int y0, input int x1, input int y1,
                      input int x2, input int y2, input int col);
    exp_cur  = model(x0, y0, x1, y1, x2, y2, col);
    exp_live = 1;
    wait_ready();
    I_P0X = 10'(x0); I_P0Y = 10'(y0);
    I_P1X = 10'(x1); I_P1Y = 10'(y1);
    I_P2X = 10'(x2); I_P2Y = 10'(y2);
    I_COLOR = 16'(col);
    I_TRI_VALID = 1'b1;
    @(posedge I_CLK); #1;
    I_TRI_VALID = 1'b0;
  endtask

  // Full transaction: latency, cull pulse width, optional backpressure, handshake release.
  task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int col, input int hold);
    send(x0, y0, x1, y1, x2, y2, col);
    repeat (6) @(posedge I_CLK);
    #1;
    check("valid_before_edge7", O_SETUP_VALID, 0);
    check("cull_before_edge7", O_CULL, 0);
    @(posedge I_CLK); #1;
    check("valid_at_edge7", O_SETUP_VALID, int'(!exp_cur.cull));
    check("cull_at_edge7", O_CULL, int'(exp_cur.cull));
    if (exp_cur.cull) begin
      check("ready_after_cull", O_TRI_READY, 1);
      @(posedge I_CLK); #1;
      check("cull_one_cycle", O_CULL, 0);
      check("no_record_after_cull", O_SETUP_VALID, 0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        I_TRI_VALID = 1'b1;
        I_P0X = 10'd5; I_P1X = 10'd300; I_P2Y = 10'd7; I_COLOR = 16'hDEAD;
        @(posedge I_CLK); #1;
        check("valid_held", O_SETUP_VALID, 1);
      end
      I_TRI_VALID   = 1'b0;
      I_SETUP_READY = 1'b1;
      @(posedge I_CLK); #1;
      I_SETUP_READY = 1'b0;
      check("valid_after_handshake", O_SETUP_VALID, 0);
      check("ready_after_handshake", O_TRI_READY, 1);
    end
    exp_live = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;

    // Literal pins on the model itself.
    m = model(1, 1, 200, 100, 50, 50, 16'h0FFF);
    check("pin_a0", m.a[0], 50);      check("pin_b0", m.b[0], -150);
    check("pin_a1", m.a[1], 49);      check("pin_b1", m.b[1], -49);
    check("pin_a2", m.a[2], -99);     check("pin_b2", m.b[2], 199);
    check("pin_e0", m.e[0], 4900);    check("pin_e1", m.e[1], 0);
    check("pin_e2", m.e[2], 0);       check("pin_xmax", m.xmax, 200);
    check("pin_ymax", m.ymax, 100);   check("pin_cull", int'(m.cull), 0);
    m = model(1, 1, 50, 50, 200, 100, 16'h1234);
    check("pin_rev_area", m.area, -4900);
    check("pin_rev_a0", m.a[0], 50);  check("pin_rev_b0", m.b[0], -150);
    check("pin_rev_e0", m.e[0], 4900);
    m = model(0, 0, 10, 10, 20, 20, 0);
    check("pin_collinear", int'(m.cull), 1);
    m = model(700, 10, 800, 10, 750, 50, 0);
    check("pin_offscreen", int'(m.cull), 1);
    m = model(600, 350, 700, 350, 600, 450, 0);
    check("pin_clamp_xmax", m.xmax, 639); check("pin_clamp_ymax", m.ymax, 399);
    check("pin_clamp_xmin", m.xmin, 600); check("pin_clamp_ymin", m.ymin, 350);

    repeat (3) @(posedge I_CLK);
    #1;
    check("rst_tri_ready", O_TRI_READY, 1);
    check("rst_setup_valid", O_SETUP_VALID, 0);
    check("rst_cull", O_CULL, 0);
    check("rst_x_min", O_X_MIN, 0);
    check("rst_e0", int'(O_E0), 0);
    check("rst_color", O_COLOR, 0);
    I_RST_N = 1'b1;
    @(posedge I_CLK); #1;

    run_tri(1, 1, 200, 100, 50, 50, 16'h0FFF, 0);
    run_tri(1, 1, 50, 50, 200, 100, 16'h1234, 0);
    check("rev_e_nonneg", int'(exp_cur.e[0] >= 0 && exp_cur.e[1] >= 0 && exp_cur.e[2] >= 0), 1);
    run_tri(0, 0, 10, 10, 20, 20, 16'h00AA, 0);
    run_tri(700, 10, 800, 10, 750, 50, 16'h00BB, 0);
    run_tri(600, 350, 700, 350, 600, 450, 16'hF00F, 0);
    run_tri(1, 1, 200, 100, 50, 50, 16'h5A5A, 5);

    // Reset while the block sits in EVAL1 (three edges after acceptance).
    send(10, 20, 300, 40, 100, 200, 16'h7777);
    repeat (3) @(posedge I_CLK);
    #1;
    exp_live = 0;
    I_RST_N  = 1'b0;
    @(posedge I_CLK); #1;
    check("midrst_tri_ready", O_TRI_READY, 1);
    check("midrst_cull", O_CULL, 0);
    check("midrst_valid", O_SETUP_VALID, 0);
    check("midrst_a0", int'(O_A0), 0);
    I_RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge I_CLK); #1;
      check("midrst_quiet", int'(O_SETUP_VALID || O_CULL), 0);
    end

    run_tri(10, 300, 300, 20, 630, 390, 16'hC0DE, 2);

    repeat (2) @(posedge I_CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_setup.md
Name: tri_setup

Overview:
- Triangle setup stage directly upstream of the GPU rasterizer.
- Accepts one triangle (three screen-space vertices plus a 16-bit colour) over a valid/ready handshake.
- Computes the clipped bounding box, the three edge-function coefficients A/B, and the edge values at the box origin. Normalises winding so that "inside" means all edges >= 0, and culls degenerate or off-screen triangles.
- Delivers one setup record per accepted triangle to the rasterizer over a second valid/ready handshake.

Parameters:
- H_RES, 640, framebuffer width in pixels.
- V_RES, 400, framebuffer height in pixels.
- COORD_W, 10, unsigned vertex coordinate width.
- COEF_W, 11, signed width of A/B coefficients (COORD_W+1).
- EDGE_W, 24, signed width of edge values and area.

Ports:
- I_CLK, in, 1, clock.
- I_RST_N, in, 1, synchronous active-low reset.
- I_TRI_VALID, in, 1, input triangle valid.
- O_TRI_READY, out, 1, block can accept a triangle.
- I_P0X, I_P0Y, I_P1X, I_P1Y, I_P2X, I_P2Y, in, COORD_W each, vertex coordinates.
- I_COLOR, in, 16, fill colour.
- O_SETUP_VALID, out, 1, setup record valid.
- I_SETUP_READY, in, 1, rasterizer accepts the record.
- O_X_MIN, O_X_MAX, O_Y_MIN, O_Y_MAX, out, COORD_W each, clipped bounding box.
- O_A0, O_B0, O_A1, O_B1, O_A2, O_B2, out, COEF_W each signed, edge coefficients.
- O_E0, O_E1, O_E2, out, EDGE_W each signed, edge values at (O_X_MIN, O_Y_MIN).
- O_COLOR, out, 16, registered copy of I_COLOR.
- O_CULL, out, 1, one-cycle pulse when an accepted triangle is dropped.

Behaviour:
Clock, reset and handshake:
- Single clock domain; reset is synchronous and active-low on I_RST_N.
- Reset values: state IDLE, O_TRI_READY=1, O_SETUP_VALID=0, O_CULL=0, all data outputs 0.
- Reset asserted mid-operation abandons the current triangle; no record and no O_CULL are produced.
- O_TRI_READY=1 only in IDLE. A triangle is accepted on an edge where I_TRI_VALID && O_TRI_READY (edge 0); all inputs are captured on that edge.

FSM, in edge order after acceptance:
- IDLE -> BBOX (edge 0): mins/maxes of x and y, using <= comparisons (ties take the lower-index vertex).
- BBOX -> COEF (edge 1):
  - A0=-(p2y-p1y), B0=p2x-p1x
  - A1=-(p0y-p2y), B1=p0x-p2x
  - A2=-(p1y-p0y), B2=p1x-p0x
  - All differences are sign-extended to COEF_W before subtracting.
- COEF -> EVAL0 -> EVAL1 -> EVAL2 -> AREA (edges 2-5): one multiply-accumulate per state through the shared edge_mac:
  - E0=A0*(x_min-p1x)+B0*(y_min-p1y)
  - E1=A1*(x_min-p2x)+B1*(y_min-p2y)
  - E2=A2*(x_min-p0x)+B2*(y_min-p0y)
  - area=A0*(p0x-p1x)+B0*(p0y-p1y)
  - Products are full width, sign-extended to EDGE_W; no saturation is needed for COORD_W=10.
- ORIENT (edge 6):
  - Cull, with O_CULL pulsed the following cycle and a return to IDLE, if area==0 or x_min>=H_RES or y_min>=V_RES.
  - If area<0, negate all A, B and E.
  - Clamp x_max to H_RES-1 and y_max to V_RES-1.
  - Otherwise go to OUT.
- OUT (edge 7): O_SETUP_VALID=1 from edge 7. Fixed latency is 7 edges from acceptance to valid.
- Culled triangles also return to IDLE at edge 7, so O_TRI_READY is high again after edge 7.

Output rules:
- While O_SETUP_VALID && !I_SETUP_READY, all outputs hold stable.
- On the edge where both are high: O_SETUP_VALID<=0, state goes to IDLE, and O_TRI_READY=1 the following cycle. There is no skid buffer: throughput is at most one triangle per 9 cycles.
- I_TRI_VALID while not ready is ignored; the upstream source must hold the triangle.
- A cull and a new accept can never coincide, since ready is low until IDLE.

Decomposition:
- Shared package gpu_pkg:
  - H_RES, V_RES, COORD_W, COEF_W, EDGE_W constants.
  - setup_state_t enum: IDLE, BBOX, COEF, EVAL0, EVAL1, EVAL2, AREA, ORIENT, OUT.
  - setup_rec_t struct holding the bbox, A/B, E and colour fields.
- One sub-module, edge_mac: a combinational signed A*dx+B*dy, with one instance time-shared across EVAL0..AREA.

Test Plan:
- Tri (1,1),(200,100),(50,50), colour 16'h0FFF:
  - bbox 1..200 x 1..100
  - A0=50, B0=-150, A1=49, B1=-49, A2=-99, B2=199
  - E0=4900, E1=0, E2=0
  - O_SETUP_VALID high after edge 7; O_COLOR=16'h0FFF.
- Tri (1,1),(50,50),(200,100), reversed winding: area=-4900, so the block negates. Required: A0=50, B0=-150, E0=4900, and all E >= 0.
- Tri (0,0),(10,10),(20,20), collinear: O_CULL pulses one cycle, O_SETUP_VALID stays 0, O_TRI_READY=1 after edge 7.
- Tri (700,10),(800,10),(750,50), off-screen: O_CULL pulses and no record is produced.
- Tri (600,350),(700,350),(600,450): O_X_MAX=639, O_Y_MAX=399, O_X_MIN=600, O_Y_MIN=350.
- Backpressure and reset:
  - Hold I_SETUP_READY=0 for 5 cycles: all outputs stable and O_TRI_READY=0; release it, and handshake completes with O_TRI_READY=1 one cycle later.
  - Assert I_RST_N=0 during EVAL1: next cycle IDLE with O_TRI_READY=1 and no O_CULL and no record.
